// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX->MEM pipeline register for the RISC-V core.
// Holds the ALU result, store data, destination register and the
// memory/writeback control bits behind a valid/ready handshake on both sides.
// Optional feature macro: EX_MEM_SKID_EN adds a second (skid) slot and a
// registered in_ready_o. Without it the stage is a single slot whose
// in_ready_o is combinational.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  flush_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  input  logic [DATA_W-1:0]     rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  reg_write_o,
  output logic                  mem_to_reg_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [1:0]            occupancy_o
);

  // One slot's contents packed as {reg_write, mem_to_reg, mem_read, mem_write,
  // alu_result, store_data, rd_addr}.
  localparam int PayW = 4 + 2 * DATA_W + REG_ADDR_W;

  logic [PayW-1:0]       in_payload;
  logic [PayW-1:0]       main_q;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  out_valid;
  logic                  in_ready;
  logic                  main_reg_write;
  logic                  main_mem_to_reg;
  logic                  main_mem_read;
  logic                  main_mem_write;

  // Writes to x0 are architecturally discarded, so never carry them forward.
  assign in_payload = {reg_write_i && (rd_addr_i != '0), mem_to_reg_i,
                       mem_read_i, mem_write_i, alu_result_i, rs2_data_i,
                       rd_addr_i};

  assign in_xfer  = in_valid_i && in_ready;
  assign out_xfer = out_valid && out_ready_i;

  assign {main_reg_write, main_mem_to_reg, main_mem_read, main_mem_write,
          alu_result_o, mem_data_o, rd_addr_o} = main_q;

  // Control bits are qualified by valid so an empty slot never issues a
  // memory access or a register writeback downstream.
  assign reg_write_o  = main_reg_write  && out_valid;
  assign mem_to_reg_o = main_mem_to_reg && out_valid;
  assign mem_read_o   = main_mem_read   && out_valid;
  assign mem_write_o  = main_mem_write  && out_valid;

  assign out_valid_o = out_valid;
  assign in_ready_o  = in_ready;

`ifdef EX_MEM_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t          state_q;
  logic [PayW-1:0] skid_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [1:0]      occ_q;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign occupancy_o = occ_q;

  // Slot FSM: main slot feeds MEM, skid slot absorbs the one instruction that
  // arrives while MEM stalls, so in_ready never depends on out_ready_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q      <= in_payload;
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_payload;
          end else if (in_xfer) begin
            skid_q     <= in_payload;
            state_q    <= ST_SKID;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd2;
          end else if (out_xfer) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

`else

  logic main_valid_q;

  assign out_valid   = main_valid_q;
  assign in_ready    = !main_valid_q || out_ready_i;
  assign occupancy_o = {1'b0, main_valid_q};

  // Single slot: refill on accept (also when draining), empty on drain or flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
    end else if (in_xfer) begin
      main_valid_q <= 1'b1;
      main_q       <= in_payload;
    end else if (out_xfer) begin
      main_valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed self-checking bench for ex_mem_stage.
// Builds with or without EX_MEM_SKID_EN; the back-pressure and flush
// scenarios follow whichever storage variant is compiled.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic        reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i;
  logic [31:0] alu_result_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o;
  logic [31:0] alu_result_o, mem_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  occupancy_o;

  int total = 0;
  int bad   = 0;

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .alu_result_o(alu_result_o),
    .mem_data_o(mem_data_o), .rd_addr_o(rd_addr_o),
    .occupancy_o(occupancy_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one EX-side instruction.
  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [31:0] st, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic mr,
                       input logic mw);
    in_valid_i   = v;
    alu_result_i = alu;
    rs2_data_i   = st;
    rd_addr_i    = rd;
    reg_write_i  = rw;
    mem_to_reg_i = m2r;
    mem_read_i   = mr;
    mem_write_i  = mw;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid_o); end
    total++;
    if (occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy_o); end
    total++;
    if ({alu_result_o, mem_data_o, rd_addr_o} !== 69'd0) begin bad++; $display("[TB] FAIL reset_data: got %h %h %h expected 0", alu_result_o, mem_data_o, rd_addr_o); end
    total++;
    if ({reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o} !== 4'b0) begin bad++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o}); end
    #10;
    rst_n_i = 1'b1;
    tick();
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 32'h10 + i;
      drive(1'b1, exp, ~exp, 5'(i + 1), 1'b1, i[0], i[1], i[2]);
      #1;
      total++;
      if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready_o); end
      tick();
      total++;
      if (out_valid_o !== 1'b1 || alu_result_o !== exp || mem_data_o !== ~exp || rd_addr_o !== 5'(i + 1))
        begin bad++; $display("[TB] FAIL stream_out[%0d]: got v=%b alu=%h st=%h rd=%0d expected v=1 alu=%h st=%h rd=%0d", i, out_valid_o, alu_result_o, mem_data_o, rd_addr_o, exp, ~exp, i + 1); end
      total++;
      if ({reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o} !== {1'b1, i[0], i[1], i[2]})
        begin bad++; $display("[TB] FAIL stream_ctrl[%0d]: got %b expected %b", i, {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o}, {1'b1, i[0], i[1], i[2]}); end
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
    total++;
    if (alu_result_o !== 32'h17 || mem_write_o !== 1'b0) begin bad++; $display("[TB] FAIL stream_hold: got alu=%h mw=%b expected alu=17 mw=0", alu_result_o, mem_write_o); end
  endtask

  task automatic test_x0();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid_o !== 1'b1 || alu_result_o !== 32'h55) begin bad++; $display("[TB] FAIL x0_out: got v=%b alu=%h expected v=1 alu=55", out_valid_o, alu_result_o); end
    total++;
    if (reg_write_o !== 1'b0 || rd_addr_o !== 5'd0) begin bad++; $display("[TB] FAIL x0_suppress: got rw=%b rd=%0d expected rw=0 rd=0", reg_write_o, rd_addr_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (alu_result_o !== 32'hDEADBEEF || out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL mrst_loaded: got v=%b alu=%h expected v=1 alu=deadbeef", out_valid_o, alu_result_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL mrst_valid: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
    total++;
    if ({alu_result_o, mem_data_o, rd_addr_o} !== 69'd0 || {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o} !== 4'b0)
      begin bad++; $display("[TB] FAIL mrst_data: got alu=%h st=%h rd=%0d ctrl=%b expected all 0", alu_result_o, mem_data_o, rd_addr_o, {reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o}); end
    #2;
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL mrst_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready_o, out_valid_o); end
  endtask

`ifdef EX_MEM_SKID_EN
  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h100, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_first: got occ=%0d rdy=%b expected occ=1 rdy=1", occupancy_o, in_ready_o); end
    drive(1'b1, 32'h104, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_skid: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy_o, in_ready_o); end
    drive(1'b1, 32'h108, 32'h3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (alu_result_o !== 32'h100 || occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold: got alu=%h occ=%0d rdy=%b expected alu=100 occ=2 rdy=0", alu_result_o, occupancy_o, in_ready_o); end
    out_ready_i = 1'b1;
    tick();
    total++;
    if (alu_result_o !== 32'h104 || occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_second: got alu=%h occ=%0d rdy=%b expected alu=104 occ=1 rdy=1", alu_result_o, occupancy_o, in_ready_o); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (alu_result_o !== 32'h108 || rd_addr_o !== 5'd3 || occupancy_o !== 2'd1) begin bad++; $display("[TB] FAIL bp_third: got alu=%h rd=%0d occ=%0d expected alu=108 rd=3 occ=1", alu_result_o, rd_addr_o, occupancy_o); end
    tick();
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL bp_empty: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1A0, 32'h7, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h1A4, 32'h8, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (occupancy_o !== 2'd2 || mem_write_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_fill: got occ=%0d mw=%b expected occ=2 mw=1", occupancy_o, mem_write_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'h200, 32'h9, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || mem_write_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_clear: got v=%b occ=%0d mw=%b expected v=0 occ=0 mw=0", out_valid_o, occupancy_o, mem_write_o); end
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b expected 1", in_ready_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid_o !== 1'b0 || alu_result_o === 32'h200) begin bad++; $display("[TB] FAIL flush_drop[%0d]: got v=%b alu=%h expected v=0 and alu!=200", i, out_valid_o, alu_result_o); end
    end
  endtask
`else
  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h300, 32'h1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h304, 32'h2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if (in_ready_o !== 1'b0 || occupancy_o !== 2'd1) begin bad++; $display("[TB] FAIL bp_full: got rdy=%b occ=%0d expected rdy=0 occ=1", in_ready_o, occupancy_o); end
    tick();
    total++;
    if (alu_result_o !== 32'h300 || mem_read_o !== 1'b1 || out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold: got alu=%h mr=%b v=%b expected alu=300 mr=1 v=1", alu_result_o, mem_read_o, out_valid_o); end
    out_ready_i = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_comb_ready: got %b expected 1", in_ready_o); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (alu_result_o !== 32'h304 || rd_addr_o !== 5'd8 || mem_read_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_replace: got alu=%h rd=%0d mr=%b expected alu=304 rd=8 mr=0", alu_result_o, rd_addr_o, mem_read_o); end
    tick();
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin bad++; $display("[TB] FAIL bp_empty: got v=%b occ=%0d expected v=0 occ=0", out_valid_o, occupancy_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h1A0, 32'h7, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (occupancy_o !== 2'd1 || mem_write_o !== 1'b1) begin bad++; $display("[TB] FAIL flush_fill: got occ=%0d mw=%b expected occ=1 mw=1", occupancy_o, mem_write_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'h200, 32'h9, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0 || mem_write_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_clear: got v=%b occ=%0d mw=%b expected v=0 occ=0 mw=0", out_valid_o, occupancy_o, mem_write_o); end
    total++;
    if (alu_result_o !== 32'h1A0) begin bad++; $display("[TB] FAIL flush_nocapture: got alu=%h expected 1a0", alu_result_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid_o !== 1'b0 || alu_result_o === 32'h200) begin bad++; $display("[TB] FAIL flush_drop[%0d]: got v=%b alu=%h expected v=0 and alu!=200", i, out_valid_o, alu_result_o); end
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_stream();
    test_x0();
    test_backpressure();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
